// File: rtl/proc_seq_pkg.sv
// Shared definitions for the processor issue sequencer.
// Contents: FSM state encoding, instruction word layout, opcode constants
// and the invalid-opcode decode used for error counting.
package proc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [2:0] OP_ALU0     = 3'b000;
  localparam logic [2:0] OP_ALU1     = 3'b001;
  localparam logic [2:0] OP_ALU2     = 3'b010;
  localparam logic [2:0] OP_ALU3     = 3'b011;
  localparam logic [2:0] OP_REGWRITE = 3'b100;

  typedef struct packed {
    logic [2:0] opcode;
    logic [3:0] num1;
    logic [3:0] num2;
  } instr_t;

  localparam int unsigned INSTR_W = $bits(instr_t);

  // True for the reserved opcodes 1x1 and 11x.
  function automatic logic is_invalid_op(input logic [2:0] opcode);
    return opcode[2] && (opcode[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// Instruction FIFO for the issue sequencer.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push, push_data     write request (ignored while full) and entry
//   pop, pop_data       read request (ignored while empty), head entry
//   full, empty         status; full is registered from occupancy
module seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW + 1)'(1);
      2'b01:   count_next = count - (AW + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // full follows the updated occupancy, so a pop only frees a slot
  // for the cycle after it happens.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == FULL_CNT);
    end
  end

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle issue controller in front of the 4-bit processor datapath.
// Buffers instructions, drives one at a time onto the datapath for a
// programmable settle window, captures result/flags and returns them on a
// valid/ready response port. Counts issued invalid-opcode instructions.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   in_valid/in_ready, in_opcode/num1/num2   instruction input
//   dp_opcode/num1/num2/write_enable   registered datapath drive
//   dp_result, dp_carry/zero/negative/invalid  datapath outputs
//   res_valid/res_ready, res_data, res_flags   response {inv,neg,zero,carry}
//   err_count                          saturating invalid-op count
//   busy                               FSM active or FIFO non-empty
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERRW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_opcode,
  input  logic [3:0]      in_num1,
  input  logic [3:0]      in_num2,
  output logic [2:0]      dp_opcode,
  output logic [3:0]      dp_num1,
  output logic [3:0]      dp_num2,
  output logic            dp_write_enable,
  input  logic [3:0]      dp_result,
  input  logic            dp_carry,
  input  logic            dp_zero,
  input  logic            dp_negative,
  input  logic            dp_invalid,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [3:0]      res_data,
  output logic [3:0]      res_flags,
  output logic [ERRW-1:0] err_count,
  output logic            busy
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

  state_t               state;
  state_t               state_next;
  logic [3:0]           settle_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  instr_t               in_instr;
  logic [INSTR_W-1:0]   head_bits;
  instr_t               head;

  assign in_instr = '{opcode: in_opcode, num1: in_num1, num2: in_num2};
  assign head     = instr_t'(head_bits);
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || !fifo_empty;

  seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_instr),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   if (settle_cnt == 4'd1) state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_opcode       <= '0;
      dp_num1         <= '0;
      dp_num2         <= '0;
      dp_write_enable <= 1'b0;
      settle_cnt      <= '0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      res_flags       <= '0;
      err_count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            dp_opcode       <= head.opcode;
            dp_num1         <= head.num1;
            dp_num2         <= head.num2;
            dp_write_enable <= (head.opcode == OP_REGWRITE);
            settle_cnt      <= SETTLE_INIT;
          end
        end
        ISSUE: begin
          // Single write pulse regardless of settle length.
          dp_write_enable <= 1'b0;
          settle_cnt      <= settle_cnt - 4'd1;
        end
        CAPTURE: begin
          res_data  <= dp_result;
          res_flags <= {dp_invalid, dp_negative, dp_zero, dp_carry};
          res_valid <= 1'b1;
          if (is_invalid_op(dp_opcode) && (err_count != '1))
            err_count <= err_count + ERRW'(1);
          dp_opcode       <= '0;
          dp_num1         <= '0;
          dp_num2         <= '0;
          dp_write_enable <= 1'b0;
        end
        RESP: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed self-checking bench for proc_sequencer, driving a behavioural
// model of the 4-bit processor datapath (16x4 register file reset to
// reg[i]=i, ALU: 000 add, 001 sub with borrow as carry, 010 and, 011 or,
// 100 register write returning 0 with no flags, others invalid).
module tb_proc_sequencer;
  import proc_seq_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 1;
  localparam int unsigned ERRW   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_opcode = '0;
  logic [3:0]      in_num1 = '0;
  logic [3:0]      in_num2 = '0;
  logic [2:0]      dp_opcode;
  logic [3:0]      dp_num1;
  logic [3:0]      dp_num2;
  logic            dp_write_enable;
  logic [3:0]      dp_result;
  logic            dp_carry;
  logic            dp_zero;
  logic            dp_negative;
  logic            dp_invalid;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [3:0]      res_data;
  logic [3:0]      res_flags;
  logic [ERRW-1:0] err_count;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  proc_sequencer #(
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE),
    .ERRW   (ERRW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_opcode       (in_opcode),
    .in_num1         (in_num1),
    .in_num2         (in_num2),
    .dp_opcode       (dp_opcode),
    .dp_num1         (dp_num1),
    .dp_num2         (dp_num2),
    .dp_write_enable (dp_write_enable),
    .dp_result       (dp_result),
    .dp_carry        (dp_carry),
    .dp_zero         (dp_zero),
    .dp_negative     (dp_negative),
    .dp_invalid      (dp_invalid),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_flags       (res_flags),
    .err_count       (err_count),
    .busy            (busy)
  );

  // Datapath model
  logic [3:0] regs [16];
  logic [3:0] a_val;
  logic [3:0] b_val;
  logic [4:0] wide;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= 4'(i);
    end else if (dp_write_enable) begin
      regs[dp_num1] <= dp_num2;
    end
  end

  always_comb begin
    a_val       = regs[dp_num1];
    b_val       = regs[dp_num2];
    wide        = '0;
    dp_result   = '0;
    dp_carry    = 1'b0;
    dp_zero     = 1'b0;
    dp_negative = 1'b0;
    dp_invalid  = 1'b0;
    case (dp_opcode)
      3'b000: wide = {1'b0, a_val} + {1'b0, b_val};
      3'b001: wide = {1'b0, a_val} - {1'b0, b_val};
      3'b010: wide = {1'b0, a_val & b_val};
      3'b011: wide = {1'b0, a_val | b_val};
      3'b100: wide = '0;
      default: dp_invalid = 1'b1;
    endcase
    if (dp_opcode[2] == 1'b0) begin
      dp_result   = wide[3:0];
      dp_carry    = wide[4];
      dp_zero     = (wide[3:0] == 4'd0);
      dp_negative = wide[3];
    end
  end

  int unsigned we_pulses = 0;
  logic [3:0]  we_n1 = '0;
  logic [3:0]  we_n2 = '0;
  always @(posedge clk) begin
    if (rst_n && dp_write_enable) begin
      we_pulses <= we_pulses + 1;
      we_n1     <= dp_num1;
      we_n2     <= dp_num2;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // All tasks start and end on a falling edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    in_opcode = '0;
    in_num1   = '0;
    in_num2   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_one(input logic [2:0] op, input logic [3:0] n1,
                          input logic [3:0] n2, output bit ok);
    in_valid  = 1'b1;
    in_opcode = op;
    in_num1   = n1;
    in_num2   = n2;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [3:0] d, output logic [3:0] f, output bit to);
    to = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (res_valid) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    d = res_data;
    f = res_flags;
    if (!to) begin
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
    end
    n_checks++;
    if ({res_valid, res_data, res_flags} !== 9'd0) begin
      n_fail++; $display("FAIL reset_res: got %0h expected 0", {res_valid, res_data, res_flags});
    end
    n_checks++;
    if ({dp_opcode, dp_num1, dp_num2, dp_write_enable} !== 12'd0) begin
      n_fail++; $display("FAIL reset_dp: got %0h expected 0", {dp_opcode, dp_num1, dp_num2, dp_write_enable});
    end
    n_checks++;
    if ({err_count, busy} !== 3'd0) begin
      n_fail++; $display("FAIL reset_err_busy: got %0h expected 0", {err_count, busy});
    end
  endtask

  task automatic test_single_alu();
    int unsigned w0;
    logic exp_v;
    do_reset();
    w0 = we_pulses;
    in_valid  = 1'b1;
    in_opcode = 3'b000;
    in_num1   = 4'd3;
    in_num2   = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      exp_v = (c == 4);
      n_checks++;
      if (res_valid !== exp_v) begin
        n_fail++; $display("FAIL alu_latency_cycle%0d: got %0b expected %0b", c, res_valid, exp_v);
      end
      if (c < 4) @(negedge clk);
    end
    n_checks++;
    if (res_data !== 4'd8) begin
      n_fail++; $display("FAIL alu_data: got %0d expected 8", res_data);
    end
    n_checks++;
    if (res_flags !== 4'b0100) begin
      n_fail++; $display("FAIL alu_flags: got %b expected 0100", res_flags);
    end
    n_checks++;
    if (we_pulses - w0 !== 0) begin
      n_fail++; $display("FAIL alu_no_write: got %0d pulses expected 0", we_pulses - w0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if ({res_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL alu_handshake: got %b expected 00", {res_valid, busy});
    end
  endtask

  task automatic test_write_read();
    int unsigned w0;
    bit ok1, ok2, to;
    logic [3:0] d, f;
    do_reset();
    w0 = we_pulses;
    push_one(3'b100, 4'd2, 4'd9, ok1);
    push_one(3'b000, 4'd2, 4'd2, ok2);
    n_checks++;
    if ({ok1, ok2} !== 2'b11) begin
      n_fail++; $display("FAIL wr_push: got %b expected 11", {ok1, ok2});
    end
    wait_resp(d, f, to);
    n_checks++;
    if ({to, d, f} !== 9'd0) begin
      n_fail++; $display("FAIL wr_first_resp: got to=%0b d=%0d f=%b expected to=0 d=0 f=0000", to, d, f);
    end
    wait_resp(d, f, to);
    n_checks++;
    if ({to, d, f} !== {1'b0, 4'd2, 4'b0001}) begin
      n_fail++; $display("FAIL wr_read_resp: got to=%0b d=%0d f=%b expected to=0 d=2 f=0001", to, d, f);
    end
    n_checks++;
    if (we_pulses - w0 !== 1 || we_n1 !== 4'd2 || we_n2 !== 4'd9) begin
      n_fail++; $display("FAIL wr_pulse: got n=%0d num1=%0d num2=%0d expected n=1 num1=2 num2=9", we_pulses - w0, we_n1, we_n2);
    end
    n_checks++;
    if (err_count !== '0) begin
      n_fail++; $display("FAIL wr_err_count: got %0d expected 0", err_count);
    end
  endtask

  task automatic test_fifo_full();
    logic [2:0] op_t [5];
    logic [3:0] n1_t [5];
    logic [3:0] n2_t [5];
    logic [3:0] ed [5];
    logic [3:0] ef [5];
    logic [3:0] d, f;
    bit to;
    op_t = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b000};
    n1_t = '{4'd1, 4'd2, 4'd12, 4'd5, 4'd8};
    n2_t = '{4'd2, 4'd7, 4'd10, 4'd10, 4'd8};
    ed   = '{4'd3, 4'd11, 4'd8, 4'd15, 4'd0};
    ef   = '{4'b0000, 4'b0101, 4'b0100, 4'b0100, 4'b0011};
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_opcode = op_t[i];
      in_num1   = n1_t[i];
      in_num2   = n2_t[i];
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL full_accept%0d: got in_ready=%0b expected 1", i, in_ready);
      end
      @(negedge clk);
    end
    in_opcode = 3'b000;
    in_num1   = 4'd1;
    in_num2   = 4'd1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({in_ready, busy} !== 2'b01) begin
        n_fail++; $display("FAIL full_stall%0d: got in_ready,busy=%b expected 01", i, {in_ready, busy});
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_resp(d, f, to);
      n_checks++;
      if ({to, d, f} !== {1'b0, ed[i], ef[i]}) begin
        n_fail++; $display("FAIL full_order%0d: got to=%0b d=%0d f=%b expected to=0 d=%0d f=%b", i, to, d, f, ed[i], ef[i]);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL full_drained: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok1, ok2, to, stable;
    logic [3:0] d, f;
    do_reset();
    push_one(3'b000, 4'd6, 4'd7, ok1);
    push_one(3'b010, 4'd15, 4'd3, ok2);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if ({ok1, ok2, to} !== 3'b110) begin
      n_fail++; $display("FAIL bp_first_valid: got push/timeout=%b expected 110", {ok1, ok2, to});
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 4'd13 || res_flags !== 4'b0100 ||
          {dp_opcode, dp_num1, dp_num2, dp_write_enable} !== 12'd0)
        stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got stable=%0b expected 1 (d=%0d f=%b)", stable, res_data, res_flags);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if ({res_valid, dp_opcode, dp_num1} !== 8'd0) begin
      n_fail++; $display("FAIL bp_after_handshake: got %0h expected 0", {res_valid, dp_opcode, dp_num1});
    end
    @(negedge clk);
    n_checks++;
    if ({dp_opcode, dp_num1, dp_num2} !== {3'b010, 4'd15, 4'd3}) begin
      n_fail++; $display("FAIL bp_next_issue: got %0h expected %0h", {dp_opcode, dp_num1, dp_num2}, {3'b010, 4'd15, 4'd3});
    end
    wait_resp(d, f, to);
    n_checks++;
    if ({to, d, f} !== {1'b0, 4'd3, 4'b0000}) begin
      n_fail++; $display("FAIL bp_second_resp: got to=%0b d=%0d f=%b expected to=0 d=3 f=0000", to, d, f);
    end
  endtask

  task automatic test_invalid();
    logic [2:0]      op_t [5];
    logic [ERRW-1:0] ec [5];
    logic [3:0]      d, f;
    bit ok, to;
    op_t = '{3'b101, 3'b110, 3'b111, 3'b101, 3'b110};
    ec   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_one(op_t[i], 4'd1, 4'd2, ok);
      wait_resp(d, f, to);
      n_checks++;
      if ({ok, to, d, f} !== {2'b10, 4'd0, 4'b1000}) begin
        n_fail++; $display("FAIL invalid_resp%0d: got ok=%0b to=%0b d=%0d f=%b expected ok=1 to=0 d=0 f=1000", i, ok, to, d, f);
      end
      n_checks++;
      if (err_count !== ec[i]) begin
        n_fail++; $display("FAIL invalid_count%0d: got %0d expected %0d", i, err_count, ec[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, stale;
    do_reset();
    push_one(3'b000, 4'd1, 4'd1, ok);
    push_one(3'b001, 4'd9, 4'd4, ok);
    push_one(3'b010, 4'd3, 4'd6, ok);
    push_one(3'b011, 4'd0, 4'd0, ok);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dp_opcode, dp_num1} !== {3'b001, 4'd9}) begin
      n_fail++; $display("FAIL mid_issue: got %0h expected %0h", {dp_opcode, dp_num1}, {3'b001, 4'd9});
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, res_valid, res_data, res_flags, busy} !== 11'b100_0000_0000) begin
      n_fail++; $display("FAIL mid_reset_res: got %b expected 10000000000", {in_ready, res_valid, res_data, res_flags, busy});
    end
    n_checks++;
    if ({dp_opcode, dp_num1, dp_num2, dp_write_enable, err_count} !== 14'd0) begin
      n_fail++; $display("FAIL mid_reset_dp: got %0h expected 0", {dp_opcode, dp_num1, dp_num2, dp_write_enable, err_count});
    end
    rst_n     = 1'b1;
    res_ready = 1'b1;
    stale     = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0 || dp_opcode !== 3'b000) stale = 1'b1;
    end
    res_ready = 1'b0;
    n_checks++;
    if (stale !== 1'b0) begin
      n_fail++; $display("FAIL mid_no_stale: got activity=%0b expected 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_write_read();
    test_fifo_full();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
- Multi-cycle issue controller sitting in front of the 4-bit processor datapath (register file plus 4-bit ALU, opcode[2:0]/num1/num2/write_enable in; 4-bit result and carry/zero/negative/invalid flags out).
- Buffers incoming instructions in a small FIFO and issues them one at a time.
- Holds datapath inputs stable for a programmable settle window, then captures result and flags.
- Returns them through a valid/ready response port and counts invalid-opcode instructions.

Parameters:
- DEPTH, 4, instruction FIFO entries; power of 2, 2..16.
- SETTLE, 1, cycles datapath inputs are held before capture; 1..15.
- ERRW, 8, width of invalid-instruction counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO can accept
- in_opcode  in  3  instruction opcode
- in_num1  in  4  operand/register address 1
- in_num2  in  4  operand/register address 2 (write data for opcode 100)
- dp_opcode  out  3  to datapath opcode
- dp_num1  out  4  to datapath num1
- dp_num2  out  4  to datapath num2
- dp_write_enable  out  1  to datapath write_enable
- dp_result  in  4  datapath FinalOutput
- dp_carry, dp_zero, dp_negative, dp_invalid  in  1 each  datapath flags
- res_valid  out  1  response available
- res_ready  in  1  consumer accepts response
- res_data  out  4  captured result
- res_flags  out  4  {invalid, negative, zero, carry} captured
- err_count  out  ERRW  count of issued instructions with opcode[2]=1, opcode[1:0]!=00; saturating
- busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - FIFO empty; in_ready=1.
  - FSM IDLE.
  - dp_* outputs all 0 (opcode 000, write_enable 0).
  - res_valid=0; res_data=0; res_flags=0.
  - err_count=0; busy=0.
- Reset mid-operation aborts everything: queued instructions and any pending response are discarded, no completion.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full. Full is registered from occupancy; a same-cycle pop does not raise in_ready.
  - Pop only on the IDLE->ISSUE transition.
  - Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
  - Simultaneous push and pop leaves occupancy unchanged.
- FSM, all outputs registered:
  - IDLE: if FIFO non-empty, pop head and load dp_opcode/num1/num2. Set dp_write_enable=1 iff opcode==100. Load settle counter with SETTLE. Go to ISSUE.
  - ISSUE: dp_write_enable drops to 0 after its first ISSUE cycle, so each write instruction gives exactly one write pulse. dp_opcode/num1/num2 are held. Counter decrements each cycle; when it reaches 1, go to CAPTURE.
  - CAPTURE:
    - One cycle. Register dp_result and flags into res_data/res_flags and set res_valid=1.
    - If opcode is invalid (1x1, 11x), err_count += 1, saturating at all-ones.
    - dp_* outputs return to 0. Go to RESP.
  - RESP: hold res_* stable while res_valid && !res_ready. On res_ready, clear res_valid, go to IDLE.
- Latency, accept to res_valid on empty FIFO: 1 cycle push + 1 IDLE + SETTLE + 1 CAPTURE; SETTLE=1 gives res_valid 3 cycles after the accepting edge.
- Minimum throughput: one instruction per SETTLE+3 cycles with res_ready held high.
- No bypass: an instruction pushed into an empty FIFO is popped the next cycle at the earliest.
- Responses are returned strictly in issue order; no reordering.
- res_flags are reported exactly as the datapath gives them:
  - opcode 100 responses carry result 0 with flags 0.
  - Invalid opcodes carry invalid=1.
- busy = (state!=IDLE) || !empty.

Decomposition:
- Shared package proc_seq_pkg:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2, RESP=2'd3.
  - Opcode constants: OP_REGWRITE=3'b100; ALU opcodes 000..011.
  - Function is_invalid_op(opcode).
- One sub-module, natural split: seq_fifo (parameterised DEPTH, 11-bit entries, push/pop/full/empty).
- FSM, settle counter, capture registers and error counter stay in proc_sequencer.
- Bench instantiates proc_sequencer driving the real processor datapath.

Test Plan:
- Reset then single ALU op: opcode 000, num1=3, num2=5, SETTLE=1. Required: dp_write_enable stays 0; res_valid 3 cycles after accept; res_data/flags equal the datapath's result for those register contents.
- Register write then read: push {100,4'd2,4'd9}, then {000,4'd2,4'd2}. Required: exactly one dp_write_enable pulse with num1=2, num2=9; second response reflects reg2=9; first response has res_data=0, flags=0000.
- FIFO full, DEPTH=4, res_ready=0: push 5 back-to-back. Required: in_ready=0 after 4 entries are held (first already popped, so the 5th is accepted); further pushes stall; responses in order once res_ready=1.
- Backpressure: hold res_ready=0 for 10 cycles. Required: res_data/res_flags stable, res_valid=1, no dp activity; next issue begins the cycle after the handshake.
- Invalid opcodes: issue 101, 110, 111. Required: res_flags[3]=1 each; err_count=3. With ERRW=2, five invalid ops saturate at 3.
- Reset mid-operation: rst_n=0 during ISSUE with 2 queued. Required: next cycle all outputs at reset values, in_ready=1; no stale response after release.
